// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock.
// Signed operands are iterated as magnitudes; the sign is restored at completion.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] acc_sum;
  logic               last;

  // -2^(WIDTH-1) negates to itself, which reads correctly as unsigned
  assign mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b = (is_signed && b[WIDTH-1]) ? -b : b;

  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last    = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    prod_d   = prod_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d  = CALC;
          acc_d    = '0;
          cnt_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        end
      end
      CALC: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
          cnt_d   = '0;
          prod_d  = neg_q ? -acc_sum : acc_sum;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      prod_q   <= prod_d;
    end
  end

  assign busy    = (state_q == CALC);
  assign done    = (state_q == DONE);
  assign product = prod_q;

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL provide port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port start  input  1  request to begin a multiply; sampled on rising clk.
REQ-005 SHALL provide port is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL provide port a  input  WIDTH  multiplicand; sampled with start.
REQ-007 SHALL provide port b  input  WIDTH  multiplier; sampled with start.
REQ-008 SHALL provide port busy  output  1  high while a multiply is in progress.
REQ-009 SHALL provide port done  output  1  one-cycle pulse, product valid.
REQ-010 SHALL provide port product  output  2*WIDTH  registered result.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-012 SHALL accept start only when busy=0 (state IDLE or DONE); start while busy=1 SHALL be ignored with no effect on the current operation.
REQ-013 On accepted start at edge k: latch a, b, is_signed; clear the accumulator; load bit counter to 0; enter CALC.
REQ-014 In signed mode, SHALL convert each operand to WIDTH-bit magnitude before iteration and record result sign = sign(a) XOR sign(b); -2^(WIDTH-1) SHALL map to magnitude 2^(WIDTH-1) without overflow.
REQ-015 In CALC, each edge SHALL examine one multiplier bit, LSB first: if 1, add the multiplicand magnitude shifted left by the bit index to a 2*WIDTH-bit accumulator; counter increments.
REQ-016 After exactly WIDTH CALC edges (edge k+WIDTH), SHALL write product (negated two's-complement if result sign = 1, else unmodified) and enter DONE.
REQ-017 busy SHALL be high for exactly WIDTH cycles, following edges k+1 .. k+WIDTH-1 inclusive of the cycle after edge k.
REQ-018 done SHALL be high for exactly one cycle, the cycle following edge k+WIDTH; DONE SHALL return to IDLE on the next edge unless a new start is accepted there, in which case SHALL go directly to CALC.
REQ-019 product SHALL hold its value from edge k+WIDTH until the next completion or reset; it SHALL NOT change during CALC.
REQ-020 Arithmetic SHALL be exact: no truncation, no overflow for any operand pair in either mode; unsigned result range 0 .. (2^WIDTH-1)^2.
REQ-021 Operand inputs changing after the start edge SHALL NOT affect the result.
REQ-022 Zero operands SHALL still take the full WIDTH cycles (fixed latency, no early termination).

Reset
REQ-023 rst high SHALL immediately, independent of clk, force state IDLE, busy=0, done=0, product=0, accumulator and counter=0.
REQ-024 rst asserted mid-CALC SHALL abort the operation; no done pulse SHALL be issued for it.
REQ-025 start sampled in the same cycle as rst high SHALL be ignored; first accepted start is on the first edge with rst low.

Verification
REQ-026 WIDTH=8, unsigned, a=255, b=255, start 1 cycle -> busy 8 cycles, done pulse 1 cycle, product=0xFE01.
REQ-027 WIDTH=8, signed, a=0x80 (-128), b=0x80 -> product=0x4000; a=0x80, b=0x7F (127) -> product=0xC080 (-16256).
REQ-028 WIDTH=4, unsigned, all 256 operand pairs back-to-back (start asserted in each DONE cycle) -> each product equals a*b, e.g. 15*15=0xE1; no idle gap between operations.
REQ-029 WIDTH=8, start a=3,b=5, then start a=7,b=7 with a/b toggling during busy -> second start ignored, product=0x000F, single done.
REQ-030 WIDTH=8, rst pulsed at CALC cycle 4 of a=200,b=100 -> busy/done/product drop to 0 asynchronously, no done; next start a=2,b=3 -> product=0x0006.
REQ-031 Random regression, WIDTH in {4,8,16}, both modes, 10k operations vs. reference model -> zero mismatches, done latency always WIDTH cycles after start edge.
